dyt_pipe_ctrl: RTL
==================

// Module: dyt_pipe_ctrl
// PURPOSE
//  Sequences the three-stage IF/ID/EX pipeline. Drives enables/flushes for the PC, the IF/ID latch
//  and the ID/EX latch from memory handshakes, EX-stage redirects, load-use hazards and halt.
//  Sits beside the datapath; its only state is the stall FSM, a wait timer and optional counters.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive MEM_WAIT cycles before mem_err; 0 disables the timeout
//  CNT_W        32   width of the perf counters (PIPE_STATS_EN only)
// PORTS
//  CLK          in   1      system clock
//  nRST         in   1      asynchronous active-low reset
//  ihit         in   1      instruction memory returned the word this cycle
//  dhit         in   1      data memory completed the access this cycle
//  ex_memRead   in   1      ID/EX latch output: instruction in EX is a load
//  ex_memWrite  in   1      ID/EX latch output: instruction in EX is a store
//  ex_RegWrite  in   1      ID/EX latch output: instruction in EX writes rd
//  ex_rd        in   5      destination register of the EX instruction
//  id_rs1       in   5      source register 1 of the ID instruction
//  id_rs2       in   5      source register 2 of the ID instruction
//  ex_redirect  in   1      EX resolves a taken branch, jump or jal (PC loads the target)
//  ex_halt      in   1      ID/EX latch output: halt instruction in EX
//  pc_en        out  1      PC register update enable
//  ifid_en      out  1      IF/ID latch load enable
//  ifid_flush   out  1      IF/ID latch loads a bubble (NOP, all controls 0)
//  idex_en      out  1      ID/EX latch load enable
//  idex_flush   out  1      ID/EX latch loads a bubble
//  halt         out  1      sticky: pipeline halted
//  mem_err      out  1      sticky: data-memory timeout
//  stall_cnt    out  CNT_W  cycles with pc_en=0 in RUN or MEM_WAIT (PIPE_STATS_EN only)
//  flush_cnt    out  CNT_W  cycles with idex_flush=1 (PIPE_STATS_EN only)
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, HALTED. Reset (nRST=0, asynchronous) -> RUN, wait timer=0, halt=0, mem_err=0, counters=0.
//  - Enables/flushes are combinational from state and inputs.
//    Reset values: pc_en=1 ifid_en=1 idex_en=1 ifid_flush=0 idex_flush=0.
//  - dmem_pend = ex_memRead|ex_memWrite. Rules are in priority order; the first match applies:
//    1. HALTED: all enables 0, all flushes 0; halt=1. Exit only by reset.
//    2. ex_halt (RUN): all enables 0. Next state HALTED. halt rises on the next edge.
//    3. dmem_pend & !dhit: freeze all (enables 0, flushes 0). State -> MEM_WAIT. Timer increments each cycle.
//       In MEM_WAIT, timer==MEM_TIMEOUT-1 with dhit still 0 -> mem_err=1, halt=1, state HALTED.
//    4. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1. If dmem_pend, this applies only in the dhit cycle.
//    5. load-use: ex_memRead & ex_RegWrite & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2), applied in the dhit cycle.
//       Response: pc_en=0, ifid_en=0, idex_flush=1. This inserts one bubble; the ID instruction is held one cycle.
//    6. !ihit: pc_en=0, ifid_en=1, ifid_flush=1 (bubble into ID); idex_en=1.
//    7. otherwise: all enables 1, flushes 0.
//  - MEM_WAIT -> RUN on the dhit cycle; the timer clears. Rules 4-7 are evaluated in that same cycle.
//  - Redirect with !ihit: redirect wins; the outstanding fetch is discarded by the PC load.
//  - Flush with the latch enable 0 is never driven: whenever a flush is asserted, its enable is also 1.
// CONFIGURATION
//  - DYT_PIPE_STATS_EN defined: stall_cnt and flush_cnt exist; both saturate at all-ones and hold in HALTED.
//  - DYT_PIPE_STATS_EN undefined: both ports and their counter logic are absent.
// STRUCTURE
//  - common_types package gains: pipe_state_t enum {RUN, MEM_WAIT, HALTED}; regbits_t (logic [4:0]).
//  - Sub-module dyt_hazard_detect: pure combinational load-use compare (ex_*/id_* -> luse).
//    Instantiated once; the FSM and timer stay in dyt_pipe_ctrl.
// TESTING
//  1. Reset: hold nRST=0 then release with ihit=1 -> pc_en=ifid_en=idex_en=1, halt=0, flushes 0.
//  2. Load in EX with dhit low 3 cycles -> all enables 0 for 3 cycles. On the dhit cycle enables=1 and state=RUN.
//  3. ex_memRead=1, ex_RegWrite=1, ex_rd=5, id_rs2=5, dhit=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1.
//     Repeat with ex_rd=0 -> no stall.
//  4. ex_redirect=1 with ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1 in that cycle.
//  5. ex_halt=1 -> next edge halt=1, all enables 0 for 10+ cycles; nRST pulse mid-halt -> RUN.
//  6. MEM_TIMEOUT=4, store with dhit stuck 0 -> mem_err=1 and halt=1 after 4 wait cycles.
//     With DYT_PIPE_STATS_EN, stall_cnt=4.

Source files
------------

// File: rtl/dyt_pipe_ctrl_pkg.sv
// Shared types for the IF/ID/EX pipeline controller.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package dyt_pipe_ctrl_pkg;

    // Stall FSM states. RUN is the reset state.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } pipe_state_t;

    // Architectural register index.
    typedef logic [4:0] regbits_t;

    // Width of the data-memory wait timer.
    // Always at least one bit, so a disabled timeout (0) still elaborates.
    function automatic int timer_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dyt_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the ID instruction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is acted on.
module dyt_hazard_detect
    import dyt_pipe_ctrl_pkg::*;
(
    input  logic     ex_memRead,
    input  logic     ex_RegWrite,
    input  regbits_t ex_rd,
    input  regbits_t id_rs1,
    input  regbits_t id_rs2,
    output logic     luse
);

    logic rd_live;
    logic rs_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        rd_live  = ex_memRead && ex_RegWrite && (ex_rd != 5'd0);
        rs_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
        luse     = rd_live && rs_match;
    end

endmodule

// File: rtl/dyt_pipe_ctrl.sv
// Pipeline sequencer: PC / IF-ID / ID-EX enables and flushes; optional stats via DYT_PIPE_STATS_EN.
// Latency: enables and flushes are combinational; halt and mem_err register on the next edge.
// Backpressure: an unfinished data access freezes the pipe; a missing fetch injects an ID bubble.
module dyt_pipe_ctrl
    import dyt_pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
`ifdef DYT_PIPE_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
)(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     ex_memRead,
    input  logic     ex_memWrite,
    input  logic     ex_RegWrite,
    input  regbits_t ex_rd,
    input  regbits_t id_rs1,
    input  regbits_t id_rs2,
    input  logic     ex_redirect,
    input  logic     ex_halt,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     ifid_flush,
    output logic     idex_en,
    output logic     idex_flush,
    output logic     halt,
    output logic     mem_err
`ifdef DYT_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int             TW       = timer_w(MEM_TIMEOUT);
    localparam logic [TW-1:0]  TMO_LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam bit             TMO_ON   = (MEM_TIMEOUT != 0);

    pipe_state_t   state_q;
    pipe_state_t   state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          mem_err_q;
    logic          err_set;
    logic          dmem_pend;
    logic          mem_stall;
    logic          luse;

    dyt_hazard_detect u_hazard (
        .ex_memRead  (ex_memRead),
        .ex_RegWrite (ex_RegWrite),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .luse        (luse)
    );

    // Data access still outstanding this cycle: the whole pipe must freeze.
    always_comb begin
        dmem_pend = ex_memRead | ex_memWrite;
        mem_stall = dmem_pend & ~dhit;
    end

    // Priority-ordered stall/flush decode plus next-state and timer update.
    // A load-use or redirect sitting behind a data access is only reached on the
    // dhit cycle, because the freeze branch above it catches every earlier cycle.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        state_d    = state_q;
        timer_d    = '0;
        err_set    = 1'b0;

        if (state_q == HALTED) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
        end else if ((state_q == RUN) && ex_halt) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            state_d = HALTED;
        end else if (mem_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            state_d = MEM_WAIT;
            timer_d = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
            if (TMO_ON && (state_q == MEM_WAIT) && (timer_q == TMO_LAST)) begin
                err_set = 1'b1;
                state_d = HALTED;
            end
        end else begin
            // Access finished (or none pending): back to RUN with a clean timer.
            state_d = RUN;
            if (ex_redirect) begin
                // The PC load also discards any fetch still in flight.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (luse) begin
                // Hold PC and the ID instruction one cycle, bubble into EX.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                // Fetch not back yet: keep PC, feed a bubble into ID.
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    // FSM state, wait timer and sticky memory-error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= RUN;
            timer_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mem_err_q <= mem_err_q | err_set;
        end
    end

    // HALTED is only left through reset, so the state itself is the sticky flag.
    always_comb begin
        halt    = (state_q == HALTED);
        mem_err = mem_err_q;
    end

`ifdef DYT_PIPE_STATS_EN
    logic stall_evt;
    logic flush_evt;

    // Counter events; nothing counts once halted, so both counters hold there.
    always_comb begin
        stall_evt = (state_q != HALTED) && !pc_en;
        flush_evt = idex_flush;
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
